// File: rtl/rstgen_pkg.sv
// rstgen_pkg: shared types and constants for the rstgen_sonata reset sequencer
// Contents: rstgen_state_e sequencer states, LockLossCntW lock-loss counter width.
package rstgen_pkg;
  localparam int LockLossCntW = 8;
  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    STAGGER,
    RUN
  } rstgen_state_e;
endpackage

// File: rtl/rstgen_sync.sv
// rstgen_sync: SyncStages-deep flop chain bringing an asynchronous level into clk_i
// Ports: clk_i destination clock; rst_i async active-high reset (chain clears to 0);
//   d_i asynchronous input level; q_o synchronized level.
module rstgen_sync
  import rstgen_pkg::*;
#(
  parameter int SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [SyncStages-1:0] sync_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else sync_q <= {sync_q[SyncStages-2:0], d_i};
  end
  assign q_o = sync_q[SyncStages-1];
endmodule

// File: rtl/rstgen_sonata.sv
// rstgen_sonata: staged reset sequencer for the clk_sys domain driven by PLL lock
// Ports: clk_sys system clock; rst_sys async active-high board reset;
//   locked_i async PLL lock status; sw_rst_req_i level software reset request;
//   sw_rst_ack_o one-cycle request acknowledge; rst_periph_no / rst_core_no
//   active-low peripheral / core resets; in_reset_o high outside RUN;
//   lock_loss_cnt_o saturating count of lock-loss events.
// Build option: define RSTGEN_SW_RST_EN to enable the software reset request path;
//   otherwise sw_rst_req_i is ignored and sw_rst_ack_o stays 0.
module rstgen_sonata
  import rstgen_pkg::*;
#(
  parameter int HoldCycles  = 1024,
  parameter int PeriphDelay = 16,
  parameter int SyncStages  = 2
) (
  input  logic                    clk_sys,
  input  logic                    rst_sys,
  input  logic                    locked_i,
  input  logic                    sw_rst_req_i,
  output logic                    sw_rst_ack_o,
  output logic                    rst_periph_no,
  output logic                    rst_core_no,
  output logic                    in_reset_o,
  output logic [LockLossCntW-1:0] lock_loss_cnt_o
);
  localparam int CntMax = (HoldCycles > PeriphDelay) ? HoldCycles : PeriphDelay;
  localparam int CntW = $clog2(CntMax);
  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] StagLast = CntW'(PeriphDelay - 1);
  rstgen_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [LockLossCntW-1:0] loss_q, loss_d;
  logic periph_q, periph_d, core_q, core_d, in_reset_q, in_reset_d, ack_q, ack_d;
  logic locked_s, lock_lost, sw_accept, sw_edge;
  rstgen_sync #(.SyncStages(SyncStages)) u_lock_sync (
    .clk_i(clk_sys),
    .rst_i(rst_sys),
    .d_i  (locked_i),
    .q_o  (locked_s)
  );
`ifdef RSTGEN_SW_RST_EN
  logic req_q, req_prev_q;
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      req_q      <= 1'b0;
      req_prev_q <= 1'b0;
    end else begin
      req_q      <= sw_rst_req_i;
      req_prev_q <= req_q;
    end
  end
  assign sw_edge = req_q & ~req_prev_q;
`else
  logic unused_sw_req;
  assign unused_sw_req = sw_rst_req_i;
  assign sw_edge = 1'b0;
`endif
  // Any state past WAIT_LOCK was entered with locked_s high, so a low locked_s
  // there is a fall. Acceptance requires locked_s, so lock loss always wins.
  always_comb begin
    lock_lost = !locked_s && state_q != WAIT_LOCK;
    sw_accept = sw_edge && locked_s && state_q == RUN;
    state_d = lock_lost ? WAIT_LOCK :
              sw_accept ? HOLD :
              (state_q == WAIT_LOCK && locked_s) ? HOLD :
              (state_q == HOLD && cnt_q == HoldLast) ? STAGGER :
              (state_q == STAGGER && cnt_q == StagLast) ? RUN : state_q;
    cnt_d = (state_d != state_q || !(state_q inside {HOLD, STAGGER})) ? '0 : cnt_q + CntW'(1);
    loss_d = (lock_lost && loss_q != '1) ? loss_q + LockLossCntW'(1) : loss_q;
    periph_d = state_d inside {STAGGER, RUN};
    core_d = state_d == RUN;
    in_reset_d = state_d != RUN;
    ack_d = sw_accept;
  end
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      loss_q     <= '0;
      periph_q   <= 1'b0;
      core_q     <= 1'b0;
      in_reset_q <= 1'b1;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      loss_q     <= loss_d;
      periph_q   <= periph_d;
      core_q     <= core_d;
      in_reset_q <= in_reset_d;
      ack_q      <= ack_d;
    end
  end
  assign rst_periph_no   = periph_q;
  assign rst_core_no     = core_q;
  assign in_reset_o      = in_reset_q;
  assign sw_rst_ack_o    = ack_q;
  assign lock_loss_cnt_o = loss_q;
endmodule

// File: tb/tb_rstgen_sonata.sv
// tb_rstgen_sonata: self-checking bench for rstgen_sonata (HoldCycles=8, PeriphDelay=4, SyncStages=2)
module tb_rstgen_sonata;
  localparam int H = 8;
  localparam int P = 4;
  localparam int S = 2;
`ifdef RSTGEN_SW_RST_EN
  localparam bit SwEn = 1'b1;
`else
  localparam bit SwEn = 1'b0;
`endif
  logic clk_sys = 1'b0;
  logic rst_sys = 1'b1;
  logic locked_i = 1'b0;
  logic sw_rst_req_i = 1'b0;
  logic sw_rst_ack_o, rst_periph_no, rst_core_no, in_reset_o;
  logic [7:0] lock_loss_cnt_o;
  int n_cmp = 0;
  int n_bad = 0;
  int n_ack = 0;
  // Reference model: elapsed edges since the hold phase began (-1 = waiting for lock).
  int since = -1;
  int loss_m = 0;
  logic ack_m = 1'b0;
  logic lk_h[S];
  logic r1, r2;
  typedef struct {
    string name;
    int at;
    logic [2:0] exp;
  } vec_t;
  vec_t tbl[6];

  rstgen_sonata #(.HoldCycles(H), .PeriphDelay(P), .SyncStages(S)) dut (
    .clk_sys        (clk_sys),
    .rst_sys        (rst_sys),
    .locked_i       (locked_i),
    .sw_rst_req_i   (sw_rst_req_i),
    .sw_rst_ack_o   (sw_rst_ack_o),
    .rst_periph_no  (rst_periph_no),
    .rst_core_no    (rst_core_no),
    .in_reset_o     (in_reset_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] outs();
    return {20'd0, sw_rst_ack_o, rst_periph_no, rst_core_no, in_reset_o, lock_loss_cnt_o};
  endfunction

  task automatic model_reset();
    since = -1;
    loss_m = 0;
    ack_m = 1'b0;
    foreach (lk_h[i]) lk_h[i] = 1'b0;
    r1 = 1'b0;
    r2 = 1'b0;
  endtask

  // lk_h[k] holds the locked_i sample from k+1 edges ago; locked_s seen at this
  // edge is the sample from S edges ago. A software edge is a 0 then 1 in the
  // two previous request samples.
  task automatic model_edge(input logic lk, input logic rq);
    logic ls, sw;
    ls = lk_h[S-1];
    sw = SwEn && r1 && !r2;
    for (int i = S - 1; i > 0; i--) lk_h[i] = lk_h[i-1];
    lk_h[0] = lk;
    r2 = r1;
    r1 = rq;
    ack_m = 1'b0;
    if (since < 0) begin
      if (ls) since = 0;
    end else if (!ls) begin
      since = -1;
      if (loss_m < 255) loss_m++;
    end else if (sw && since >= H + P) begin
      since = 0;
      ack_m = 1'b1;
    end else if (since < H + P) since++;
  endtask

  task automatic check_model();
    logic [31:0] e;
    e = {20'd0, ack_m, since >= H, since >= H + P, since < H + P, 8'(loss_m)};
    if (sw_rst_ack_o === 1'b1) n_ack++;
    chk("model", outs(), e);
  endtask

  task automatic step(input logic lk, input logic rq);
    locked_i = lk;
    sw_rst_req_i = rq;
    @(posedge clk_sys);
    if (rst_sys) model_reset();
    else model_edge(lk, rq);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_sys = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_sys = 1'b0;
  endtask

  task automatic wait_periph(output int n);
    n = -1;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b0);
      if (rst_periph_no === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e, n;
    logic lk, rq;
    tbl[0] = '{name: "pu_e1", at: 1, exp: 3'b001};
    tbl[1] = '{name: "pu_e9", at: 9, exp: 3'b001};
    tbl[2] = '{name: "pu_e10", at: 10, exp: 3'b101};
    tbl[3] = '{name: "pu_e13", at: 13, exp: 3'b101};
    tbl[4] = '{name: "pu_e14", at: 14, exp: 3'b110};
    tbl[5] = '{name: "pu_e16", at: 16, exp: 3'b110};
    model_reset();
    repeat (3) step(1'b0, 1'b0);
    chk("reset_vals", outs(), 32'h100);
    rst_sys = 1'b0;
    e = 0;
    for (int i = 0; i < 6; i++) begin
      while (e <= tbl[i].at) begin
        step(1'b1, 1'b0);
        e++;
      end
      chk(tbl[i].name, {29'd0, rst_periph_no, rst_core_no, in_reset_o}, {29'd0, tbl[i].exp});
    end
    chk("pu_cnt", 32'(lock_loss_cnt_o), 0);
    // lock glitch in HOLD
    do_reset();
    repeat (6) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    chk("glitch_cnt", 32'(lock_loss_cnt_o), 1);
    wait_periph(n);
    chk("glitch_release", n, S + H);
    repeat (P) step(1'b1, 1'b0);
    chk("glitch_core", 32'(rst_core_no), 1);
    // lock loss in RUN
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("loss_e1", {30'd0, rst_periph_no, rst_core_no}, 3);
    step(1'b0, 1'b0);
    chk("loss_e2", {30'd0, rst_periph_no, rst_core_no}, 0);
    chk("loss_cnt", 32'(lock_loss_cnt_o), 2);
    wait_periph(n);
    chk("relock_release", n, S + H);
    repeat (P) step(1'b1, 1'b0);
    chk("relock_core", 32'(rst_core_no), 1);
    // software request in RUN, then held high
    n_ack = 0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("sw_ack", 32'(sw_rst_ack_o), 32'(SwEn));
    chk("sw_core", 32'(rst_core_no), 32'(!SwEn));
    repeat (100) step(1'b1, 1'b1);
    chk("sw_one_ack", n_ack, 32'(SwEn));
    chk("sw_rerun", 32'(rst_core_no), 1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    // lock loss coinciding with a software edge
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("simul_ack", 32'(sw_rst_ack_o), 0);
    chk("simul_core", 32'(rst_core_no), 0);
    chk("simul_cnt", 32'(lock_loss_cnt_o), 3);
    wait_periph(n);
    chk("simul_relock", n, S + H);
    // async reset mid-STAGGER
    step(1'b1, 1'b0);
    #2;
    rst_sys = 1'b1;
    #1;
    chk("async_rst", outs(), 32'h100);
    model_reset();
    step(1'b0, 1'b0);
    rst_sys = 1'b0;
    // saturation over 300 drop/relock cycles
    for (int i = 0; i < 300; i++) begin
      repeat (S + 2) step(1'b1, 1'b0);
      repeat (S + 1) step(1'b0, 1'b0);
    end
    chk("sat_cnt", 32'(lock_loss_cnt_o), 255);
    // randomized traffic against the model
    do_reset();
    lk = 1'b0;
    rq = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) lk = !lk;
      if ($urandom_range(0, 5) == 0) rq = !rq;
      step(lk, rq);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rstgen_sonata.md
# rstgen_sonata

Reset sequencer that consumes the PLL `locked` status and the board reset, and produces staged, synchronously released resets for the `clk_sys` domain. It sits directly downstream of the clock generator in the FPGA top level. It holds the system in reset until the PLL has been locked for a programmable time, releases peripherals before the core, and re-enters reset on lock loss or on a software request.

## Interface
- `HoldCycles`, 1024: `clk_sys` cycles that `locked` must stay high before any reset release; ≥2.
- `PeriphDelay`, 16: cycles between peripheral release and core release; ≥1.
- `SyncStages`, 2: flop stages in the `locked_i` synchronizer; ≥2.
- `clk_sys` input 1: system clock, the buffered PLL output.
- `rst_sys` input 1: asynchronous, active-high board reset. The integrator guarantees deassertion is synchronous to `clk_sys`.
- `locked_i` input 1: PLL lock status, asynchronous to `clk_sys`.
- `sw_rst_req_i` input 1: software reset request, level, `clk_sys` domain.
- `sw_rst_ack_o` output 1: one-cycle acknowledge pulse.
- `rst_periph_no` output 1: active-low peripheral reset.
- `rst_core_no` output 1: active-low core reset.
- `in_reset_o` output 1: high whenever the state is not RUN.
- `lock_loss_cnt_o` output 8: saturating count of lock-loss events.

## Operation
- All outputs are registered. While `rst_sys` is high: `rst_periph_no`=0, `rst_core_no`=0, `in_reset_o`=1, `sw_rst_ack_o`=0, `lock_loss_cnt_o`=0, state = WAIT_LOCK, counter = 0.
- `locked_s` is `locked_i` after `SyncStages` flops. Nothing else uses `locked_i` directly.
- States:
  - WAIT_LOCK → HOLD when `locked_s`=1. The counter clears on entry.
  - HOLD counts up. When count = HoldCycles−1 → STAGGER. If `locked_s`=0 → WAIT_LOCK.
  - STAGGER has `rst_periph_no`=1 and counts up. When count = PeriphDelay−1 → RUN. If `locked_s`=0 → WAIT_LOCK.
  - RUN has both resets deasserted. If `locked_s`=0 → WAIT_LOCK. On a software request → HOLD.
- Lock loss:
  - A fall of `locked_s` in HOLD, STAGGER or RUN increments `lock_loss_cnt_o`. The count saturates at 255.
  - In the same cycle, both resets assert and `in_reset_o`=1.
- Software request:
  - A rising edge of `sw_rst_req_i` is taken from a registered copy of the request.
  - The request is accepted only in RUN. Acceptance asserts both resets, pulses `sw_rst_ack_o` for exactly 1 cycle, and enters HOLD with the counter cleared.
  - Edges in any other state are dropped. A held-high request never retriggers.
- Simultaneous events: lock loss beats a software request. The state goes to WAIT_LOCK, the count increments, and no ack is issued.
- Counter width is $clog2(max(HoldCycles, PeriphDelay)). The counter never wraps; it clears on every state entry.

## Timing
- `locked_i` rises before edge E0. `locked_s` is high after E(SyncStages−1), and HOLD is entered at E(SyncStages).
- `rst_periph_no` rises at E(SyncStages+HoldCycles).
- `rst_core_no` rises at E(SyncStages+HoldCycles+PeriphDelay).
- `locked_i` falls before edge E0: both resets are low after E(SyncStages).
- Software acceptance: the request rises before E0 and is registered at E0. Both resets drop, and `sw_rst_ack_o` is high for the cycle, after E1.
- `rst_sys` assertion drives all outputs to their reset values asynchronously, in any state. This includes mid-HOLD or mid-STAGGER.

## Configuration
- `RSTGEN_SW_RST_EN` defined: software reset request and acknowledge behave as described above.
- `RSTGEN_SW_RST_EN` undefined: the ports remain, `sw_rst_req_i` is ignored, `sw_rst_ack_o` is tied to 0, and RUN exits only on lock loss. No edge-detect flop is generated.

## Structure
- Package `rstgen_pkg` holds the enum `rstgen_state_e` (WAIT_LOCK, HOLD, STAGGER, RUN) and the `LockLossCntW`=8 constant.
- Sub-module `rstgen_sync`: a parameterised `SyncStages` flop chain with asynchronous reset to 0. It is instantiated once for `locked_i`.

## Test plan
Unless stated otherwise, benches use HoldCycles=8, PeriphDelay=4, SyncStages=2.
- Power-up: release `rst_sys`, raise `locked_i` before E0 → `rst_periph_no` rises at E10, `rst_core_no` at E14, `in_reset_o` falls at E14.
- Lock glitch in HOLD: drop `locked_i` for 3 cycles at the 5th HOLD cycle → WAIT_LOCK, count=1, full 8-cycle hold restarts, no early release.
- Lock loss in RUN: drop `locked_i` → both resets low 2 edges later, count increments. Relock → same 8+4 sequence.
- Software reset (macro on): pulse `sw_rst_req_i` in RUN → one-cycle ack, release after 8+4 cycles. Holding the request high 100 cycles → exactly one ack. With the macro off → no ack and no reset.
- `rst_sys` mid-STAGGER → all outputs at reset values immediately, count=0.
- 300 lock drop/relock cycles → `lock_loss_cnt_o`=255.
